// File: rtl/otter_iobus_responder.sv
// OTTER IO-bus responder: decodes the CPU's IO window and owns the board-facing
// registers. These are synchronized switches, debounced buttons, LED and
// seven-segment output registers, and a compare-match timer with a level interrupt.
// Every output is driven straight from a flop.
module otter_iobus_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h1100_0000,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          PRESCALE        = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  input  logic [15:0] SWITCHES,
  input  logic [3:0]  BUTTONS,
  output logic [15:0] LEDS,
  output logic [15:0] SSEG_DATA,
  output logic        TIMER_IRQ
);

  // Word offsets inside the IO window.
  localparam logic [7:0] OFF_SW   = 8'h00;
  localparam logic [7:0] OFF_BTN  = 8'h04;
  localparam logic [7:0] OFF_LED  = 8'h20;
  localparam logic [7:0] OFF_SSEG = 8'h40;
  localparam logic [7:0] OFF_CNT  = 8'h60;
  localparam logic [7:0] OFF_CMP  = 8'h64;
  localparam logic [7:0] OFF_CTRL = 8'h68;

  // The debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int             DCW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DCW-1:0] DB_MAX = DCW'(DEBOUNCE_CYCLES - 1);

  // The prescaler counts 0..PRESCALE-1. Use one bit even when PRESCALE is 1.
  localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [31:0]          r_iobus_in;
  logic [15:0]          r_leds;
  logic [15:0]          r_sseg;
  logic [15:0]          r_sw_meta;
  logic [15:0]          r_sw_sync;
  logic [3:0]           r_btn_meta;
  logic [3:0]           r_btn_sync;
  logic [3:0]           r_btn_db;
  logic [3:0][DCW-1:0]  r_db_cnt;
  logic [31:0]          r_cnt;
  logic [31:0]          r_cmp;
  logic [PW-1:0]        r_presc;
  logic                 r_en;
  logic                 r_irq_en;
  logic                 r_pending;
  logic                 r_irq;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic       w_hit;
  logic [7:0] w_off;
  logic       w_wr_led;
  logic       w_wr_sseg;
  logic       w_wr_cmp;
  logic       w_wr_ctrl;

  assign w_hit = (IOBUS_ADDR[31:8] == BASE_ADDR[31:8]) && (IOBUS_ADDR[1:0] == 2'b00);
  assign w_off = IOBUS_ADDR[7:0];

  // Only the RW offsets have write enables. Writes to RO or unmapped offsets fall through.
  assign w_wr_led  = IOBUS_WR && w_hit && (w_off == OFF_LED);
  assign w_wr_sseg = IOBUS_WR && w_hit && (w_off == OFF_SSEG);
  assign w_wr_cmp  = IOBUS_WR && w_hit && (w_off == OFF_CMP);
  assign w_wr_ctrl = IOBUS_WR && w_hit && (w_off == OFF_CTRL);

  // ---------------------------------------------------------------------------
  // Read mux (registered below, so a same-cycle write is not visible yet)
  // ---------------------------------------------------------------------------
  logic [31:0] w_rd_data;

  // Select read data from the current register contents. Unmapped addresses read 0.
  always_comb begin
    w_rd_data = 32'h0000_0000;
    if (w_hit) begin
      case (w_off)
        OFF_SW:   w_rd_data = {16'h0000, r_sw_sync};
        OFF_BTN:  w_rd_data = {28'h000_0000, r_btn_db};
        OFF_LED:  w_rd_data = {16'h0000, r_leds};
        OFF_SSEG: w_rd_data = {16'h0000, r_sseg};
        OFF_CNT:  w_rd_data = r_cnt;
        OFF_CMP:  w_rd_data = r_cmp;
        OFF_CTRL: w_rd_data = {29'h0000_0000, r_irq_en, r_pending, r_en};
        default:  w_rd_data = 32'h0000_0000;
      endcase
    end else begin
      w_rd_data = 32'h0000_0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Timer next-state
  // ---------------------------------------------------------------------------
  logic          w_tick;
  logic          w_match;
  logic [PW-1:0] w_presc_nxt;
  logic [31:0]   w_cnt_nxt;
  logic [31:0]   w_cmp_nxt;
  logic          w_en_nxt;
  logic          w_irq_en_nxt;
  logic          w_pending_nxt;

  assign w_tick  = r_en && (r_presc == PRESC_MAX);
  assign w_match = w_tick && (r_cnt == r_cmp);

  // Compute the next timer state. A CMP write restarts counting.
  // A match takes priority over a W1C clear of pending on the same edge.
  always_comb begin
    w_presc_nxt   = r_presc;
    w_cnt_nxt     = r_cnt;
    w_cmp_nxt     = r_cmp;
    w_en_nxt      = r_en;
    w_irq_en_nxt  = r_irq_en;
    w_pending_nxt = r_pending;

    if (r_en) begin
      if (w_tick) begin
        w_presc_nxt = '0;
      end else begin
        w_presc_nxt = r_presc + PW'(1'b1);
      end
    end else begin
      w_presc_nxt = r_presc;
    end

    if (w_match) begin
      w_cnt_nxt     = 32'h0000_0000;
      w_pending_nxt = 1'b1;
    end else if (w_tick) begin
      w_cnt_nxt = r_cnt + 32'd1;
    end else begin
      w_cnt_nxt = r_cnt;
    end

    if (w_wr_cmp) begin
      w_cmp_nxt   = IOBUS_OUT;
      w_cnt_nxt   = 32'h0000_0000;
      w_presc_nxt = '0;
    end else begin
      w_cmp_nxt = r_cmp;
    end

    if (w_wr_ctrl) begin
      w_en_nxt     = IOBUS_OUT[0];
      w_irq_en_nxt = IOBUS_OUT[2];
      if (IOBUS_OUT[1] && !w_match) begin
        w_pending_nxt = 1'b0;
      end else begin
        w_pending_nxt = w_pending_nxt;
      end
    end else begin
      w_en_nxt     = r_en;
      w_irq_en_nxt = r_irq_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Register the bus read data and the LED and seven-segment output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_iobus_in <= 32'h0000_0000;
      r_leds     <= 16'h0000;
      r_sseg     <= 16'h0000;
    end else begin
      r_iobus_in <= w_rd_data;
      if (w_wr_led) begin
        r_leds <= IOBUS_OUT[15:0];
      end
      if (w_wr_sseg) begin
        r_sseg <= IOBUS_OUT[15:0];
      end
    end
  end

  // Pass switches and buttons through two-flop synchronizers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sw_meta  <= 16'h0000;
      r_sw_sync  <= 16'h0000;
      r_btn_meta <= 4'h0;
      r_btn_sync <= 4'h0;
    end else begin
      r_sw_meta  <= SWITCHES;
      r_sw_sync  <= r_sw_meta;
      r_btn_meta <= BUTTONS;
      r_btn_sync <= r_btn_meta;
    end
  end

  // Debounce each button on its own. A differing level must persist for
  // DEBOUNCE_CYCLES edges before it is accepted. Any return to the accepted level restarts the count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_btn_db <= 4'h0;
      r_db_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_btn_sync[i] != r_btn_db[i]) begin
          if (r_db_cnt[i] == DB_MAX) begin
            r_btn_db[i] <= r_btn_sync[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DCW'(1'b1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Timer state. The interrupt is registered from the next pending and
  // irq_en values, so it moves on the same edge as pending.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc   <= '0;
      r_cnt     <= 32'h0000_0000;
      r_cmp     <= 32'h0000_0000;
      r_en      <= 1'b0;
      r_irq_en  <= 1'b0;
      r_pending <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_presc   <= w_presc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cmp     <= w_cmp_nxt;
      r_en      <= w_en_nxt;
      r_irq_en  <= w_irq_en_nxt;
      r_pending <= w_pending_nxt;
      r_irq     <= w_pending_nxt & w_irq_en_nxt;
    end
  end

  assign IOBUS_IN  = r_iobus_in;
  assign LEDS      = r_leds;
  assign SSEG_DATA = r_sseg;
  assign TIMER_IRQ = r_irq;

endmodule
